// File: rtl/fir_dac_conditioner_pkg.sv
// Shared constants and types for the FIR-to-DAC conditioning path.
// The DAC code is offset binary, so midscale 12'h800 is the zero-output code.
package fir_dac_conditioner_pkg;

  localparam int DAC_W = 12;
  localparam logic [DAC_W-1:0] DAC_MID = 12'h800;
  localparam int S_MIN = -2048;
  localparam int S_MAX = 2047;

  typedef enum logic [1:0] {
    IDLE,
    SET,
    WAIT_HI,
    WAIT_LO
  } dac_state_t;

  typedef struct packed {
    logic             sat;
    logic [DAC_W-1:0] code;
  } dac_code_t;

endpackage

// File: rtl/sync_sample_fifo.sv
// Small synchronous sample FIFO with extra-MSB pointers for full/empty detection.
// A pop in the same cycle as a push on a full FIFO frees the slot, so the push lands.
module sync_sample_fifo
  import fir_dac_conditioner_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = DAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fir_dac_conditioner.sv
// Scales, rounds and saturates FIR results to 12-bit offset-binary DAC codes,
// queues them, and paces them into the DAC writer through its set/busy handshake.
module fir_dac_conditioner
  import fir_dac_conditioner_pkg::*;
#(
  parameter int SHIFT   = 16,
  parameter int DEPTH   = 4,
  parameter int BUSY_TO = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_tvalid,
  input  logic [31:0] s_tdata,
  input  logic        dac_busy,
  output logic [11:0] dac_value,
  output logic        dac_set,
  output logic [15:0] sat_count,
  output logic [15:0] drop_count,
  output logic        fifo_empty
);

  localparam int ACC_W = 33;
  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) <<< (SHIFT - 1);
  localparam int TW = $clog2(BUSY_TO) + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(BUSY_TO - 1);

  // One extra headroom bit keeps the rounding add from wrapping.
  function automatic logic signed [ACC_W-1:0] round_shift(input logic [31:0] x);
    logic signed [ACC_W-1:0] sum;
    sum = $signed({x[31], x}) + HALF;
    return sum >>> SHIFT;
  endfunction

  function automatic dac_code_t clamp_code(input logic signed [ACC_W-1:0] r);
    dac_code_t         c;
    logic signed [11:0] v;
    if (r > ACC_W'(S_MAX)) begin
      v     = 12'sd2047;
      c.sat = 1'b1;
    end else if (r < ACC_W'(S_MIN)) begin
      v     = -12'sd2048;
      c.sat = 1'b1;
    end else begin
      v     = r[11:0];
      c.sat = 1'b0;
    end
    c.code = v ^ DAC_MID;
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  logic                    vld_p1;
  logic                    vld_p2;
  logic signed [ACC_W-1:0] r_p1;
  logic [11:0]             code_p2;
  dac_code_t               clamp_p1;
  logic [11:0]             fifo_head;
  logic                    fifo_full;
  logic                    pop;
  dac_state_t              state;
  dac_state_t              state_next;
  logic [TW-1:0]           timer;
  logic [TW-1:0]           timer_next;

  assign clamp_p1 = clamp_code(r_p1);

  // Stage 1: round and shift; stage 2: clamp and offset to DAC code.
  always_ff @(posedge clk) begin
    r_p1    <= round_shift(s_tdata);
    code_p2 <= clamp_p1.code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= s_tvalid;
      vld_p2 <= vld_p1;
    end
  end

  sync_sample_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DAC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_p2),
    .pop   (pop),
    .din   (code_p2),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count  <= '0;
      drop_count <= '0;
      dac_value  <= DAC_MID;
    end else begin
      if (vld_p1 && clamp_p1.sat)        sat_count  <= sat_inc(sat_count);
      if (vld_p2 && fifo_full && !pop)   drop_count <= sat_inc(drop_count);
      if (pop)                           dac_value  <= fifo_head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  // WAIT_HI gives up after BUSY_TO cycles so a writer that never raises busy cannot hang us.
  always_comb begin
    state_next = state;
    timer_next = timer;
    pop        = 1'b0;
    dac_set    = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty && !dac_busy) begin
          pop        = 1'b1;
          state_next = SET;
        end
      end
      SET: begin
        dac_set    = 1'b1;
        timer_next = '0;
        state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (dac_busy)                 state_next = WAIT_LO;
        else if (timer == TIMER_LAST) state_next = IDLE;
        else                          timer_next = timer + TW'(1);
      end
      WAIT_LO: begin
        if (!dac_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fir_dac_conditioner.sv
// Self-checking bench for fir_dac_conditioner: directed scenarios plus randomized
// bursts checked against an arithmetic reference model and a DAC writer stand-in.
module tb_fir_dac_conditioner;

  localparam int SHIFT   = 16;
  localparam int DEPTH   = 4;
  localparam int BUSY_TO = 4;

  logic        clk;
  logic        rst;
  logic        s_tvalid;
  logic [31:0] s_tdata;
  logic        dac_busy;
  logic [11:0] dac_value;
  logic        dac_set;
  logic [15:0] sat_count;
  logic [15:0] drop_count;
  logic        fifo_empty;

  logic man_busy;
  logic auto_mode;
  logic wr_busy;
  int   wr_cnt = 0;
  int   cyc = 0;
  int   total_cnt = 0;
  int   pass_cnt = 0;

  logic [11:0] set_q[$];
  int          set_cyc[$];

  fir_dac_conditioner #(
    .SHIFT   (SHIFT),
    .DEPTH   (DEPTH),
    .BUSY_TO (BUSY_TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_tvalid   (s_tvalid),
    .s_tdata    (s_tdata),
    .dac_busy   (dac_busy),
    .dac_value  (dac_value),
    .dac_set    (dac_set),
    .sat_count  (sat_count),
    .drop_count (drop_count),
    .fifo_empty (fifo_empty)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign wr_busy  = (wr_cnt > 0);
  assign dac_busy = auto_mode ? wr_busy : man_busy;

  // Stand-in DAC writer: busy for a random 0..3 half-cycle-aligned cycles after each start.
  always @(negedge clk) begin
    if (dac_set === 1'b1) wr_cnt <= int'($urandom_range(0, 3));
    else if (wr_cnt > 0)  wr_cnt <= wr_cnt - 1;
  end

  always @(negedge clk) begin
    if (dac_set === 1'b1) begin
      set_q.push_back(dac_value);
      set_cyc.push_back(cyc);
    end
  end

  // Reference: floor((x + 2^(SHIFT-1)) / 2^SHIFT), clamp, then offset by midscale.
  function automatic logic [11:0] ref_code(input logic [31:0] x, output bit sat);
    longint v, d, n, q;
    v = longint'($signed(x));
    d = longint'(1) << SHIFT;
    n = v + d / 2;
    if (n >= 0) q = n / d;
    else        q = -((-n + d - 1) / d);
    sat = 1'b1;
    if (q > 2047)       q = 2047;
    else if (q < -2048) q = -2048;
    else                sat = 1'b0;
    return 12'(q + 2048);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    set_q.delete();
    set_cyc.delete();
  endtask

  task automatic send(input logic [31:0] d, output int n);
    s_tdata  = d;
    s_tvalid = 1'b1;
    n        = cyc;
    tick();
    s_tvalid = 1'b0;
  endtask

  task automatic wait_sets(input int num, input int budget, output bit ok);
    int k;
    k = 0;
    while (set_q.size() < num && k < budget) begin
      tick();
      k++;
    end
    ok = (set_q.size() >= num);
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (dac_value !== 12'h800) $display("FAIL reset_value: got %h, expected 800", dac_value);
    else pass_cnt++;
    total_cnt++;
    if (dac_set !== 1'b0) $display("FAIL reset_set: got %b, expected 0", dac_set);
    else pass_cnt++;
    total_cnt++;
    if (sat_count !== 16'd0) $display("FAIL reset_sat: got %0d, expected 0", sat_count);
    else pass_cnt++;
    total_cnt++;
    if (drop_count !== 16'd0) $display("FAIL reset_drop: got %0d, expected 0", drop_count);
    else pass_cnt++;
    total_cnt++;
    if (fifo_empty !== 1'b1) $display("FAIL reset_empty: got %b, expected 1", fifo_empty);
    else pass_cnt++;
  endtask

  task automatic test_round();
    logic [31:0] din [3];
    logic [11:0] exp [3];
    int n;
    bit ok;
    din[0] = 32'h0001_8000; exp[0] = 12'h802;
    din[1] = 32'hFFFF_8000; exp[1] = 12'h800;
    din[2] = 32'hFFFE_8000; exp[2] = 12'h7FF;
    auto_mode = 1'b0;
    man_busy  = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_q.delete();
      set_cyc.delete();
      send(din[i], n);
      wait_sets(1, 20, ok);
      total_cnt++;
      if (!ok) $display("FAIL round_timeout[%0d]: got no dac_set, expected one", i);
      else pass_cnt++;
      if (ok) begin
        total_cnt++;
        if (set_q[0] !== exp[i]) $display("FAIL round_value[%0d]: got %h, expected %h", i, set_q[0], exp[i]);
        else pass_cnt++;
        total_cnt++;
        if (set_cyc[0] !== n + 4) $display("FAIL round_latency[%0d]: got %0d, expected %0d", i, set_cyc[0] - n, 4);
        else pass_cnt++;
      end
      repeat (10) tick();
      total_cnt++;
      if (dac_value !== exp[i]) $display("FAIL round_hold[%0d]: got %h, expected %h", i, dac_value, exp[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturate();
    int n;
    bit ok;
    do_reset();
    send(32'h0900_0000, n);
    repeat (12) tick();
    send(32'hF700_0000, n);
    wait_sets(2, 30, ok);
    total_cnt++;
    if (!ok) $display("FAIL sat_timeout: got %0d sets, expected 2", set_q.size());
    else pass_cnt++;
    if (ok) begin
      total_cnt++;
      if (set_q[0] !== 12'hFFF) $display("FAIL sat_pos: got %h, expected fff", set_q[0]);
      else pass_cnt++;
      total_cnt++;
      if (set_q[1] !== 12'h000) $display("FAIL sat_neg: got %h, expected 000", set_q[1]);
      else pass_cnt++;
    end
    total_cnt++;
    if (sat_count !== 16'd2) $display("FAIL sat_count: got %0d, expected 2", sat_count);
    else pass_cnt++;
    repeat (10) tick();
  endtask

  task automatic test_overflow();
    int n;
    man_busy = 1'b1;
    do_reset();
    for (int k = 1; k <= 6; k++) send(32'(k) << 16, n);
    repeat (6) tick();
    total_cnt++;
    if (drop_count !== 16'd2) $display("FAIL ovf_drop: got %0d, expected 2", drop_count);
    else pass_cnt++;
    total_cnt++;
    if (set_q.size() != 0) $display("FAIL ovf_hold: got %0d sets, expected 0", set_q.size());
    else pass_cnt++;
    total_cnt++;
    if (fifo_empty !== 1'b0) $display("FAIL ovf_empty: got %b, expected 0", fifo_empty);
    else pass_cnt++;
    man_busy = 1'b0;
    repeat (45) tick();
    total_cnt++;
    if (set_q.size() != 4) $display("FAIL ovf_count: got %0d, expected 4", set_q.size());
    else pass_cnt++;
    for (int i = 0; i < 4 && i < set_q.size(); i++) begin
      total_cnt++;
      if (set_q[i] !== 12'h801 + 12'(i)) $display("FAIL ovf_order[%0d]: got %h, expected %h", i, set_q[i], 12'h801 + 12'(i));
      else pass_cnt++;
    end
    total_cnt++;
    if (fifo_empty !== 1'b1) $display("FAIL ovf_drain: got %b, expected 1", fifo_empty);
    else pass_cnt++;
  endtask

  task automatic test_busy_timeout();
    int n;
    bit ok;
    man_busy = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) send(32'(k + 10) << 16, n);
    wait_sets(3, 40, ok);
    total_cnt++;
    if (!ok) $display("FAIL to_count: got %0d sets, expected 3", set_q.size());
    else pass_cnt++;
    if (ok) begin
      for (int i = 0; i < 3; i++) begin
        total_cnt++;
        if (set_q[i] !== 12'h80A + 12'(i)) $display("FAIL to_value[%0d]: got %h, expected %h", i, set_q[i], 12'h80A + 12'(i));
        else pass_cnt++;
      end
      for (int i = 1; i < 3; i++) begin
        total_cnt++;
        if (set_cyc[i] - set_cyc[i-1] !== 6) $display("FAIL to_spacing[%0d]: got %0d, expected 6", i, set_cyc[i] - set_cyc[i-1]);
        else pass_cnt++;
      end
    end
    repeat (10) tick();
  endtask

  task automatic test_reset_mid();
    int n;
    int k;
    bit ok;
    man_busy = 1'b0;
    do_reset();
    send(32'h0005_0000, n);
    send(32'h0006_0000, n);
    send(32'h0007_0000, n);
    k = 0;
    while (dac_set !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    man_busy = 1'b1;
    repeat (4) tick();
    total_cnt++;
    if (fifo_empty !== 1'b0) $display("FAIL rmid_queued: got empty=%b, expected 0", fifo_empty);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_q.delete();
    set_cyc.delete();
    total_cnt++;
    if (fifo_empty !== 1'b1) $display("FAIL rmid_empty: got %b, expected 1", fifo_empty);
    else pass_cnt++;
    total_cnt++;
    if (dac_value !== 12'h800) $display("FAIL rmid_value: got %h, expected 800", dac_value);
    else pass_cnt++;
    total_cnt++;
    if (sat_count !== 16'd0 || drop_count !== 16'd0)
      $display("FAIL rmid_counters: got sat=%0d drop=%0d, expected 0 0", sat_count, drop_count);
    else pass_cnt++;
    repeat (3) tick();
    man_busy = 1'b0;
    repeat (20) tick();
    total_cnt++;
    if (set_q.size() != 0) $display("FAIL rmid_quiet: got %0d sets, expected 0", set_q.size());
    else pass_cnt++;
    send(32'h0003_0000, n);
    wait_sets(1, 20, ok);
    total_cnt++;
    if (!ok || set_q[0] !== 12'h803) $display("FAIL rmid_resume: got %0d sets, expected one with 803", set_q.size());
    else pass_cnt++;
    repeat (10) tick();
  endtask

  task automatic test_random();
    logic [11:0] exp_q[$];
    int exp_sat;
    int n;
    int mode;
    int kv;
    bit sat;
    bit ok;
    logic [31:0] d;
    auto_mode = 1'b1;
    do_reset();
    exp_sat = 0;
    for (int b = 0; b < 12; b++) begin
      int len;
      len = int'($urandom_range(1, DEPTH));
      for (int j = 0; j < len; j++) begin
        mode = int'($urandom_range(0, 3));
        d = $urandom;
        if (mode == 1) d = {{5{d[27]}}, d[26:0]};
        else if (mode == 2) begin
          kv = int'($urandom_range(0, 4095)) - 2048;
          d  = 32'(kv * 65536 + 32768);
        end else if (mode == 3) d = 32'h07FF_7FFF + $urandom_range(0, 2);
        exp_q.push_back(ref_code(d, sat));
        if (sat) exp_sat++;
        send(d, n);
      end
      repeat (50) tick();
    end
    wait_sets(exp_q.size(), 100, ok);
    total_cnt++;
    if (set_q.size() != exp_q.size()) $display("FAIL rnd_count: got %0d, expected %0d", set_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < set_q.size(); i++) begin
      total_cnt++;
      if (set_q[i] !== exp_q[i]) $display("FAIL rnd_value[%0d]: got %h, expected %h", i, set_q[i], exp_q[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (sat_count !== 16'(exp_sat)) $display("FAIL rnd_sat: got %0d, expected %0d", sat_count, exp_sat);
    else pass_cnt++;
    total_cnt++;
    if (drop_count !== 16'd0) $display("FAIL rnd_drop: got %0d, expected 0", drop_count);
    else pass_cnt++;
    auto_mode = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    s_tvalid  = 1'b0;
    s_tdata   = '0;
    man_busy  = 1'b0;
    auto_mode = 1'b0;
    repeat (3) tick();
    test_reset();
    test_round();
    test_saturate();
    test_overflow();
    test_busy_timeout();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
